streaming_dwc: RTL and testbench

STREAMING_DWC -- requirements
Module: streaming_dwc

---
 rtl/streaming_pkg.sv | 14 +
 rtl/streaming_dwc_if.sv | 33 +++
 rtl/streaming_dwc.sv | 106 ++++++++++
 tb/tb_streaming_dwc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/streaming_pkg.sv
// Shared constants for the streaming width converter: default geometry and the
// width of the buffered-bit counter.
package streaming_pkg;

    localparam int unsigned DWC_IN_W        = 16;
    localparam int unsigned DWC_OUT_W       = 24;
    localparam int unsigned DWC_FRAME_WORDS = 1024;
    localparam int unsigned FILL_W          = $clog2(DWC_IN_W + DWC_OUT_W + 1);

    function automatic int unsigned fill_width(input int unsigned in_w, input int unsigned out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

endpackage

// File: rtl/streaming_dwc_if.sv
// AXI-Stream style bundle around streaming_dwc: upstream word stream in,
// repacked word stream out, plus the buffered-bit count.
interface streaming_dwc_if
    import streaming_pkg::*;
#(
    parameter int unsigned IN_W  = DWC_IN_W,
    parameter int unsigned OUT_W = DWC_OUT_W
) (
    input logic clk
);

    logic [IN_W-1:0]                  in_tdata;
    logic                             in_tvalid;
    logic                             in_tready;
    logic [OUT_W-1:0]                 out_tdata;
    logic                             out_tvalid;
    logic                             out_tready;
    logic [$clog2(IN_W+OUT_W+1)-1:0]  fill;

    // master: the environment feeding the converter and draining its output
    modport master (
        input  clk,
        output in_tdata, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tvalid, fill
    );

    modport slave (
        input  clk,
        input  in_tdata, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tvalid, fill
    );

endinterface

// File: rtl/streaming_dwc.sv
// Packs an IN_W-bit word stream into OUT_W-bit words LSB-first; the tail of every
// frame is flushed as a zero-padded word so frames never share an output word.
module streaming_dwc
    import streaming_pkg::*;
#(
    parameter int unsigned IN_W        = DWC_IN_W,
    parameter int unsigned OUT_W       = DWC_OUT_W,
    parameter int unsigned FRAME_WORDS = DWC_FRAME_WORDS
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [IN_W-1:0]                  in0_V_TDATA,
    input  logic                             in0_V_TVALID,
    output logic                             in0_V_TREADY,
    output logic [OUT_W-1:0]                 out_V_TDATA,
    output logic                             out_V_TVALID,
    input  logic                             out_V_TREADY,
    output logic [$clog2(IN_W+OUT_W+1)-1:0]  fill
);

    localparam int unsigned BUF_W = IN_W + OUT_W;
    localparam int unsigned FW    = fill_width(IN_W, OUT_W);
    localparam int unsigned CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [FW-1:0]    L_IN   = FW'(IN_W);
    localparam logic [FW-1:0]    L_OUT  = FW'(OUT_W);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(FRAME_WORDS - 1);

    if (IN_W == 0 || OUT_W == 0 || FRAME_WORDS == 0) begin : g_param_check
        $error("streaming_dwc: IN_W, OUT_W and FRAME_WORDS must all be non-zero");
    end

    logic [BUF_W-1:0] r_buf;
    logic [FW-1:0]    r_fill;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_flush;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [BUF_W-1:0] w_buf_shift;
    logic [BUF_W-1:0] w_buf_next;
    logic [FW-1:0]    w_base;
    logic [FW-1:0]    w_fill_next;
    logic [OUT_W-1:0] w_out_data;

    // Both handshake outputs decode registered state only, so out_V_TREADY never
    // reaches in0_V_TREADY combinationally.
    assign in0_V_TREADY = !r_flush && (r_fill <= L_OUT);
    assign out_V_TVALID = (r_fill >= L_OUT) || (r_flush && (r_fill != '0));
    assign w_in_fire    = in0_V_TVALID && in0_V_TREADY;
    assign w_out_fire   = out_V_TVALID && out_V_TREADY;
    assign out_V_TDATA  = w_out_data;
    assign fill         = r_fill;

    always_comb begin
        w_out_data = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (FW'(i) < r_fill) begin
                w_out_data[i] = r_buf[i];
            end
        end
    end

    // The incoming word lands after the outgoing word has been shifted away.
    always_comb begin
        w_buf_shift = r_buf;
        w_base      = r_fill;
        if (w_out_fire) begin
            w_buf_shift = r_buf >> OUT_W;
            w_base      = (r_fill >= L_OUT) ? (r_fill - L_OUT) : '0;
        end
        w_buf_next  = w_buf_shift;
        w_fill_next = w_base;
        if (w_in_fire) begin
            w_buf_next  = w_buf_shift | (BUF_W'(in0_V_TDATA) << w_base);
            w_fill_next = w_base + L_IN;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_frame_cnt <= '0;
            r_flush     <= 1'b0;
        end else if (w_in_fire) begin
            if (r_frame_cnt == L_LAST) begin
                r_frame_cnt <= '0;
                r_flush     <= 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end else if (w_fill_next == '0) begin
            r_flush <= 1'b0;
        end
    end

endmodule

// File: tb/tb_streaming_dwc.sv
// Scoreboard bench for streaming_dwc: three instances (frame sizes 1024, 4 and 3)
// checked against a bit-queue packing model.
module tb_streaming_dwc;
    import streaming_pkg::*;

    localparam int unsigned IW  = DWC_IN_W;
    localparam int unsigned OW  = DWC_OUT_W;
    localparam int unsigned NI  = 3;
    localparam int unsigned FWR = $clog2(IW + OW + 1);

    function automatic int unsigned frame_words(input int g);
        case (g)
            0:       return DWC_FRAME_WORDS;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0]  drv_data  [NI];
    logic           drv_valid [NI];
    logic           drv_ready [NI];
    logic           mon_in_ready [NI];
    logic [OW-1:0]  mon_data  [NI];
    logic           mon_valid [NI];
    logic [FWR-1:0] mon_fill  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        streaming_dwc_if #(.IN_W(IW), .OUT_W(OW)) u_if (.clk(clk));

        assign u_if.in_tdata   = drv_data[g];
        assign u_if.in_tvalid  = drv_valid[g];
        assign u_if.out_tready = drv_ready[g];
        assign mon_in_ready[g] = u_if.in_tready;
        assign mon_data[g]     = u_if.out_tdata;
        assign mon_valid[g]    = u_if.out_tvalid;
        assign mon_fill[g]     = u_if.fill;

        streaming_dwc #(
            .IN_W(IW),
            .OUT_W(OW),
            .FRAME_WORDS(frame_words(g))
        ) u_dut (
            .ap_clk       (clk),
            .ap_rst       (rst),
            .in0_V_TDATA  (u_if.in_tdata),
            .in0_V_TVALID (u_if.in_tvalid),
            .in0_V_TREADY (u_if.in_tready),
            .out_V_TDATA  (u_if.out_tdata),
            .out_V_TVALID (u_if.out_tvalid),
            .out_V_TREADY (u_if.out_tready),
            .fill         (u_if.fill)
        );
    end

    int checks   = 0;
    int failures = 0;

    bit            bitq [NI][$];
    logic [OW-1:0] expq [NI][$];
    int unsigned   wcnt [NI];
    int unsigned   out_cnt [NI];
    logic          prev_hold [NI];
    logic [OW-1:0] prev_data [NI];
    bit            rand_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: every accepted word appends IN_W bits; each OUT_W bits form a word;
    // a frame's leftover bits become one zero-padded word.
    function automatic void model_accept(input int g, input logic [IW-1:0] d);
        logic [OW-1:0] w;
        for (int b = 0; b < IW; b++) bitq[g].push_back(d[b]);
        wcnt[g]++;
        while (bitq[g].size() >= OW) begin
            w = '0;
            for (int b = 0; b < OW; b++) w[b] = bitq[g].pop_front();
            expq[g].push_back(w);
        end
        if (wcnt[g] == frame_words(g)) begin
            wcnt[g] = 0;
            if (bitq[g].size() > 0) begin
                w = '0;
                for (int b = 0; bitq[g].size() > 0; b++) w[b] = bitq[g].pop_front();
                expq[g].push_back(w);
            end
        end
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                bitq[g].delete();
                expq[g].delete();
                wcnt[g]      = 0;
                prev_hold[g] = 1'b0;
            end else begin
                if (prev_hold[g]) begin
                    chk("hold_valid", 64'(mon_valid[g]), 64'd1);
                    chk("hold_data", 64'(mon_data[g]), 64'(prev_data[g]));
                end
                if (mon_valid[g] && drv_ready[g]) begin
                    out_cnt[g]++;
                    if (expq[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_unexpected inst%0d: got 0x%0h, want no output", g, mon_data[g]);
                    end else begin
                        chk($sformatf("out_data inst%0d", g), 64'(mon_data[g]), 64'(expq[g].pop_front()));
                    end
                end
                if (drv_valid[g] && mon_in_ready[g]) model_accept(g, drv_data[g]);
                prev_hold[g] = mon_valid[g] && !drv_ready[g];
                prev_data[g] = mon_data[g];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic send(input int g, input logic [IW-1:0] d, output int waits);
        waits        = 0;
        drv_data[g]  = d;
        drv_valid[g] = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_in_ready[g]) break;
            waits++;
            if (waits > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout inst%0d: got no in0_V_TREADY, want it within 500 cycles", g);
                break;
            end
        end
        @(posedge clk);
        #1;
        drv_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        for (int t = 0; t < 3000; t++) begin
            if (mon_fill[g] == '0 && expq[g].size() == 0) break;
            cyc();
        end
        chk("drain_fill", 64'(mon_fill[g]), 64'd0);
        chk("drain_queue_empty", 64'(expq[g].size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int maxw;
        int acc;
        logic [OW-1:0] held;

        for (int g = 0; g < NI; g++) begin
            drv_data[g]  = '0;
            drv_valid[g] = 1'b0;
            drv_ready[g] = 1'b0;
            out_cnt[g]   = 0;
        end
        do_reset();

        for (int g = 0; g < NI; g++) begin
            chk("rst_out_valid", 64'(mon_valid[g]), 64'd0);
            chk("rst_in_ready", 64'(mon_in_ready[g]), 64'd1);
            chk("rst_out_data", 64'(mon_data[g]), 64'd0);
            chk("rst_fill", 64'(mon_fill[g]), 64'd0);
        end

        // Back-to-back words with a free-running sink
        drv_ready[0] = 1'b1;
        send(0, 16'h1111, w);
        send(0, 16'h2222, w);
        chk("lat_valid", 64'(mon_valid[0]), 64'd1);
        chk("lat_data", 64'(mon_data[0]), 64'h221111);
        chk("lat_fill", 64'(mon_fill[0]), 64'd32);
        send(0, 16'h3333, w);
        drain(0);
        chk("b2b_out_count", 64'(out_cnt[0]), 64'd2);

        // Blocked sink: only two words fit before input backpressure
        do_reset();
        drv_ready[0] = 1'b0;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 16'($urandom);
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mon_in_ready[0]) acc++;
            @(posedge clk);
            #1;
            drv_data[0] = 16'($urandom);
        end
        drv_valid[0] = 1'b0;
        chk("stall_accepted", 64'(acc), 64'd2);
        chk("stall_in_ready", 64'(mon_in_ready[0]), 64'd0);
        chk("stall_fill", 64'(mon_fill[0]), 64'd32);
        chk("stall_valid", 64'(mon_valid[0]), 64'd1);
        held = mon_data[0];
        cyc();
        cyc();
        cyc();
        chk("stall_data_stable", 64'(mon_data[0]), 64'(held));
        drv_ready[0] = 1'b1;
        cyc();
        chk("stall_release_fill", 64'(mon_fill[0]), 64'd8);

        // Reset mid-frame discards buffered bits
        do_reset();
        drv_ready[0] = 1'b0;
        send(0, 16'h5555, w);
        chk("mid_fill", 64'(mon_fill[0]), 64'd16);
        rst = 1'b1;
        cyc();
        chk("mid_rst_fill", 64'(mon_fill[0]), 64'd0);
        chk("mid_rst_valid", 64'(mon_valid[0]), 64'd0);
        rst = 1'b0;
        drv_ready[0] = 1'b1;
        send(0, 16'h1111, w);
        send(0, 16'h2222, w);
        chk("post_rst_data", 64'(mon_data[0]), 64'h221111);
        send(0, 16'h3333, w);
        drain(0);

        // Four-word frame: tail flushed as a padded word
        drv_ready[1] = 1'b1;
        out_cnt[1]   = 0;
        send(1, 16'hAAAA, w);
        send(1, 16'hBBBB, w);
        send(1, 16'hCCCC, w);
        send(1, 16'hDDDD, w);
        chk("flush_in_ready", 64'(mon_in_ready[1]), 64'd0);
        chk("flush_valid", 64'(mon_valid[1]), 64'd1);
        chk("flush_data", 64'(mon_data[1]), 64'h00DDDD);
        cyc();
        chk("flush_done_fill", 64'(mon_fill[1]), 64'd0);
        chk("flush_done_in_ready", 64'(mon_in_ready[1]), 64'd1);
        chk("flush_out_count", 64'(out_cnt[1]), 64'd3);

        // Three-word frames pack exactly: no padding, at most one stall cycle
        drv_ready[2] = 1'b1;
        out_cnt[2]   = 0;
        maxw = 0;
        for (int i = 0; i < 6; i++) begin
            send(2, 16'($urandom), w);
            if (w > maxw) maxw = w;
        end
        chk("exact_max_stall", 64'(maxw <= 1), 64'd1);
        drain(2);
        chk("exact_out_count", 64'(out_cnt[2]), 64'd4);

        // Ten default frames with random valid/ready
        do_reset();
        out_cnt[0] = 0;
        rand_done  = 1'b0;
        fork
            begin
                int wr;
                for (int i = 0; i < 10 * int'(DWC_FRAME_WORDS); i++) begin
                    if ($urandom_range(0, 3) == 0) cyc();
                    send(0, 16'($urandom), wr);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    drv_ready[0] = ($urandom_range(0, 3) != 0);
                    cyc();
                end
            end
        join
        drv_ready[0] = 1'b1;
        drain(0);
        chk("rand_out_count", 64'(out_cnt[0]), 64'd6830);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
